// File: rtl/cond_point_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cond_point_multi_pkg
// Brief    : Shared types for the conditioned interaction point.
// Revision : 1.0 - initial release
// ============================================================================
package cond_point_multi_pkg;

  localparam int MAX_NCOND = 8;
  localparam int OP_W      = 6;

  typedef enum logic [OP_W-1:0] {
    OP_LESS       = 6'b000001,
    OP_GREATER    = 6'b000010,
    OP_LESS_EQ    = 6'b000100,
    OP_GREATER_EQ = 6'b001000,
    OP_EQ         = 6'b010000,
    OP_TRIGGER    = 6'b100000
  } op_t;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_WAIT    = 5'b00010,
    ST_ENABLED = 5'b00100,
    ST_URGENT  = 5'b01000,
    ST_FINAL   = 5'b10000
  } cp_state_t;

endpackage
`default_nettype wire

// File: rtl/cond_point_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : cond_point_multi_if
// Brief    : Scheduler/event-side signal bundle of the interaction point.
// Revision : 1.0 - initial release
// ============================================================================
interface cond_point_multi_if #(
  parameter int WIDTH = 32,
  parameter int NCOND = 4,
  parameter int CNT_W = 16
);
  logic                   start;
  logic                   tick;
  logic                   ext_e;
  logic                   kill_p;
  logic                   skip_p;
  logic                   rearm;
  logic [NCOND*WIDTH-1:0] value_event;
  logic [NCOND*WIDTH-1:0] value_cond;
  logic [NCOND*6-1:0]     op_cond;
  logic [NCOND-1:0]       cond_mask;
  logic                   comb_and;
  logic                   timeout_fire;
  logic [CNT_W-1:0]       dmin;
  logic [CNT_W-1:0]       dmax;
  logic                   event_t;
  logic                   skip;
  logic                   set_enable;
  logic [CNT_W-1:0]       elapsed;
  logic                   active;

  modport master (
    output start, tick, ext_e, kill_p, skip_p, rearm,
           value_event, value_cond, op_cond, cond_mask,
           comb_and, timeout_fire, dmin, dmax,
    input  event_t, skip, set_enable, elapsed, active
  );

  modport slave (
    input  start, tick, ext_e, kill_p, skip_p, rearm,
           value_event, value_cond, op_cond, cond_mask,
           comb_and, timeout_fire, dmin, dmax,
    output event_t, skip, set_enable, elapsed, active
  );
endinterface
`default_nettype wire

// File: rtl/cond_point_multi_cond_eval.sv
`default_nettype none
// ============================================================================
// Module   : cond_eval
// Brief    : Single-slot unsigned compare selected by a one-hot operator.
// Revision : 1.0 - initial release
// ============================================================================
module cond_eval
  import cond_point_multi_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_event,
  input  logic [WIDTH-1:0] value_cond,
  input  logic [OP_W-1:0]  op,
  output logic             hit
);

  // Non-one-hot operator codes never match, so they evaluate to 0
  always_comb begin
    hit = 1'b0;
    case (op)
      OP_LESS:       hit = (value_event <  value_cond);
      OP_GREATER:    hit = (value_event >  value_cond);
      OP_LESS_EQ:    hit = (value_event <= value_cond);
      OP_GREATER_EQ: hit = (value_event >= value_cond);
      OP_EQ:         hit = (value_event == value_cond);
      OP_TRIGGER:    hit = 1'b1;
      default:       hit = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cond_point_multi.sv
`default_nettype none
// ============================================================================
// Module   : cond_point_multi
// Brief    : Multi-condition interaction point with temporal window and URGENT delay.
// Revision : 1.0 - initial release
// ============================================================================
module cond_point_multi
  import cond_point_multi_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NCOND   = 4,
  parameter int CNT_W   = 16,
  parameter int URG_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  cond_point_multi_if.slave  bus
);

  localparam int                URG_W    = (URG_LAT > 1) ? $clog2(URG_LAT) : 1;
  localparam logic [URG_W-1:0]  URG_LAST = URG_W'(URG_LAT - 1);

  cp_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_elapsed, w_elapsed_nxt, w_elapsed_inc, w_dlim;
  logic [URG_W-1:0] r_urg_cnt, w_urg_nxt;
  logic [CNT_W:0]   w_el_p1;
  logic [NCOND-1:0] w_hit;
  logic             w_cond_ok, w_reach_min, w_reach_max;
  logic             w_event_t, w_skip, w_set_en;

  for (genvar gi = 0; gi < NCOND; gi++) begin : g_slot
    cond_eval #(.WIDTH(WIDTH)) u_eval (
      .value_event (bus.value_event[gi*WIDTH +: WIDTH]),
      .value_cond  (bus.value_cond[gi*WIDTH +: WIDTH]),
      .op          (bus.op_cond[gi*OP_W +: OP_W]),
      .hit         (w_hit[gi])
    );
  end

  // Unmasked slots are neutral: 1 for AND, 0 for OR
  assign w_cond_ok = bus.comb_and ? (&(w_hit | ~bus.cond_mask))
                                  : (|(w_hit & bus.cond_mask));

  assign w_elapsed_inc = (&r_elapsed) ? r_elapsed : (r_elapsed + CNT_W'(1));
  assign w_el_p1       = {1'b0, r_elapsed} + (CNT_W+1)'(1);
  assign w_dlim        = (bus.dmax > bus.dmin) ? bus.dmax : bus.dmin;
  assign w_reach_min   = (w_el_p1 >= {1'b0, bus.dmin});
  assign w_reach_max   = (w_el_p1 >= {1'b0, w_dlim});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_elapsed <= '0;
      r_urg_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_elapsed <= w_elapsed_nxt;
      r_urg_cnt <= w_urg_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_elapsed_nxt = r_elapsed;
    w_urg_nxt     = r_urg_cnt;
    w_event_t     = 1'b0;
    w_skip        = 1'b0;
    w_set_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.kill_p) begin
          w_state_nxt = ST_FINAL;
        end else if (bus.skip_p) begin
          w_skip      = 1'b1;
          w_state_nxt = ST_FINAL;
        end else if (bus.start) begin
          w_elapsed_nxt = '0;
          if (bus.dmin == '0) w_state_nxt = ST_ENABLED;
          else                w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.kill_p) begin
          w_state_nxt = ST_FINAL;
        end else if (bus.skip_p) begin
          w_skip      = 1'b1;
          w_state_nxt = ST_FINAL;
        end else if (bus.tick) begin
          w_elapsed_nxt = w_elapsed_inc;
          if (w_reach_min) w_state_nxt = ST_ENABLED;
        end
      end
      ST_ENABLED: begin
        if (bus.kill_p) begin
          w_state_nxt = ST_FINAL;
        end else if (bus.skip_p) begin
          w_skip      = 1'b1;
          w_state_nxt = ST_FINAL;
        end else begin
          if (bus.tick) w_elapsed_nxt = w_elapsed_inc;
          // A qualified external event beats a timeout on the same tick
          if (bus.ext_e && w_cond_ok) begin
            w_set_en    = 1'b1;
            w_urg_nxt   = '0;
            w_state_nxt = ST_URGENT;
          end else if (bus.tick && w_reach_max) begin
            w_event_t   = bus.timeout_fire;
            w_skip      = ~bus.timeout_fire;
            w_state_nxt = ST_FINAL;
          end
        end
      end
      ST_URGENT: begin
        if (bus.kill_p) begin
          w_state_nxt = ST_FINAL;
        end else if (bus.skip_p) begin
          w_skip      = 1'b1;
          w_state_nxt = ST_FINAL;
        end else if (r_urg_cnt == URG_LAST) begin
          w_event_t   = 1'b1;
          w_state_nxt = ST_FINAL;
        end else begin
          w_urg_nxt = r_urg_cnt + URG_W'(1);
        end
      end
      ST_FINAL: begin
        if (bus.rearm) begin
          w_elapsed_nxt = '0;
          w_state_nxt   = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Pulses are Mealy outputs; masking with rst keeps them quiet while held in reset
  assign bus.event_t    = w_event_t & ~rst;
  assign bus.skip       = w_skip & ~rst;
  assign bus.set_enable = w_set_en & ~rst;
  assign bus.elapsed    = r_elapsed;
  assign bus.active     = (r_state == ST_WAIT) || (r_state == ST_ENABLED) ||
                          (r_state == ST_URGENT);

endmodule
`default_nettype wire
